// File: rtl/aes_dec_wb_if.sv
// aes_dec_wb_if: WISHBONE classic slave bus bundle for the AES-128 decrypt front-end.
// The master modport is the bus initiator; the slave modport is aes_dec_wb.
interface aes_dec_wb_if;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [7:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/aes_dec_wb.sv
// aes_dec_wb: WISHBONE register front-end for the AES-128 inverse cipher core.
// Software loads CT/KEY words, sets START; the block runs key expansion when the
// stored key has not been expanded yet, pulses the core's text load, then captures
// the plaintext on the core's done strobe (or flags ERR after a timeout).
// Optional feature macro: AES_DEC_IRQ_EN adds the irq_o port and the CTRL IRQ_EN bit.
module aes_dec_wb #(
    parameter int KEXP_CYCLES = 12,
    parameter int TMO_CYCLES  = 64
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    aes_dec_wb_if.slave  wb,
    output logic [127:0] key_o,
    output logic [127:0] ciphertext_o,
    input  logic [127:0] plaintext_i,
    output logic         kld_o,
    output logic         ld_o,
    input  logic         dec_done_i
`ifdef AES_DEC_IRQ_EN
    ,
    output logic         irq_o
`endif
);

    // Counter is wide enough for both KEXP_CYCLES and TMO_CYCLES up to 255.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        KEXP,
        LOAD,
        BUSY
    } stateT;

    stateT              r_state;
    stateT              w_nextState;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_ack;
    logic [31:0]        r_datO;
    logic [31:0]        r_ct  [4];
    logic [31:0]        r_key [4];
    logic [31:0]        r_pt  [4];
    logic               r_startReq;
    logic               r_done;
    logic               r_err;
    logic               r_keyValid;
`ifdef AES_DEC_IRQ_EN
    logic               r_irqEn;
    logic               r_irq;
`endif

    logic               w_access;
    logic               w_wr;
    logic [5:0]         w_regIdx;
    logic               w_busy;
    logic               w_ctWr;
    logic               w_keyWr;
    logic               w_ctrlWr;
    logic               w_startWr;
    logic               w_keyNewWr;
    logic               w_statWr;
    logic [31:0]        w_rdData;
    logic               w_kld;
    logic               w_ld;
    logic               w_kexpDone;
    logic               w_capture;
    logic               w_timeout;
    logic               w_unusedAdr;

    assign w_access    = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_wr        = w_access & wb.wb_we_i;
    assign w_regIdx    = wb.wb_adr_i[7:2];
    assign w_unusedAdr = &{1'b0, wb.wb_adr_i[1:0]};
    assign w_busy      = (r_state != IDLE);

    // Core inputs must stay stable while an operation runs, so CT/KEY writes are dropped when busy.
    assign w_ctWr      = w_wr & (w_regIdx[5:2] == 4'd0) & ~w_busy;
    assign w_keyWr     = w_wr & (w_regIdx[5:2] == 4'd1) & ~w_busy;
    assign w_ctrlWr    = w_wr & (w_regIdx == 6'd12) & wb.wb_sel_i[0];
    assign w_startWr   = w_ctrlWr & wb.wb_dat_i[0] & ~w_busy;
    assign w_keyNewWr  = w_ctrlWr & wb.wb_dat_i[1];
    assign w_statWr    = w_wr & (w_regIdx == 6'd13) & wb.wb_sel_i[0];

    assign key_o        = {r_key[0], r_key[1], r_key[2], r_key[3]};
    assign ciphertext_o = {r_ct[0], r_ct[1], r_ct[2], r_ct[3]};
    assign kld_o        = w_kld;
    assign ld_o         = w_ld;
    assign wb.wb_ack_o  = r_ack;
    assign wb.wb_dat_o  = r_datO;
`ifdef AES_DEC_IRQ_EN
    assign irq_o        = r_irq;
`endif

    // Register read multiplexer; unmapped offsets read as zero.
    always_comb begin
        w_rdData = 32'h0;
        if (w_regIdx[5:2] == 4'd0) begin
            w_rdData = r_ct[w_regIdx[1:0]];
        end else if (w_regIdx[5:2] == 4'd1) begin
            w_rdData = r_key[w_regIdx[1:0]];
        end else if (w_regIdx[5:2] == 4'd2) begin
            w_rdData = r_pt[w_regIdx[1:0]];
        end else if (w_regIdx == 6'd12) begin
`ifdef AES_DEC_IRQ_EN
            w_rdData = {29'h0, r_irqEn, 2'b00};
`else
            w_rdData = 32'h0;
`endif
        end else if (w_regIdx == 6'd13) begin
            w_rdData = {28'h0, r_err, r_keyValid, r_done, w_busy};
        end
    end

    // Registered acknowledge: one ack cycle per access, read data presented alongside it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack  <= 1'b0;
            r_datO <= 32'h0;
        end else begin
            r_ack  <= w_access;
            r_datO <= (w_access && !wb.wb_we_i) ? w_rdData : 32'h0;
        end
    end

    // Byte-enabled CT/KEY storage and plaintext capture from the core.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 4; i++) begin
                r_ct[i]  <= 32'h0;
                r_key[i] <= 32'h0;
                r_pt[i]  <= 32'h0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_ctWr && wb.wb_sel_i[b]) begin
                    r_ct[w_regIdx[1:0]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
                if (w_keyWr && wb.wb_sel_i[b]) begin
                    r_key[w_regIdx[1:0]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
            end
            if (w_capture) begin
                r_pt[0] <= plaintext_i[127:96];
                r_pt[1] <= plaintext_i[95:64];
                r_pt[2] <= plaintext_i[63:32];
                r_pt[3] <= plaintext_i[31:0];
            end
        end
    end

    // Control/status flags: START request pulse, sticky DONE/ERR with W1C, KEY_VALID tracking.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_startReq <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_keyValid <= 1'b0;
        end else begin
            r_startReq <= w_startWr;
            if (w_capture) begin
                r_done <= 1'b1;
            end else if (w_startWr || (w_statWr && wb.wb_dat_i[1])) begin
                r_done <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_startWr || (w_statWr && wb.wb_dat_i[3])) begin
                r_err <= 1'b0;
            end
            if (w_keyNewWr || w_keyWr) begin
                r_keyValid <= 1'b0;
            end else if (w_kexpDone) begin
                r_keyValid <= 1'b1;
            end
        end
    end

`ifdef AES_DEC_IRQ_EN
    // Interrupt enable bit and registered interrupt request from DONE/ERR.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_irqEn <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_ctrlWr) begin
                r_irqEn <= wb.wb_dat_i[2];
            end
            r_irq <= r_irqEn & (r_done | r_err);
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Per-state cycle counter, restarted on every state change.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt <= '0;
        end else if (r_state != w_nextState) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // FSM next-state and pulse outputs; pulses decode the state so reset drops them at once.
    always_comb begin
        w_nextState = r_state;
        w_kld       = 1'b0;
        w_ld        = 1'b0;
        w_kexpDone  = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_startReq) begin
                    w_nextState = r_keyValid ? LOAD : KEXP;
                end
            end
            KEXP: begin
                w_kld = (r_cnt == '0);
                if (r_cnt == CNT_W'(KEXP_CYCLES)) begin
                    w_kexpDone  = 1'b1;
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_ld        = 1'b1;
                w_nextState = BUSY;
            end
            BUSY: begin
                if (dec_done_i) begin
                    w_capture   = 1'b1;
                    w_nextState = IDLE;
                end else if (r_cnt == CNT_W'(TMO_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_dec_wb.sv
// tb_aes_dec_wb: self-checking bench for aes_dec_wb with a stub AES core.
// The stub answers the FIPS-197 vector with its known plaintext and any other
// key/ciphertext pair with a simple reversible mix; expected values come from
// the words the bench itself wrote.
module tb_aes_dec_wb;

    localparam int KEXP = 12;
    localparam int TMO  = 64;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] keyO;
    logic [127:0] ctO;
    logic [127:0] ptI = '0;
    logic         kld;
    logic         ld;
    logic         decDone = 1'b0;
`ifdef AES_DEC_IRQ_EN
    logic         irq;
`endif

    aes_dec_wb_if wbBus ();

    aes_dec_wb #(.KEXP_CYCLES(KEXP), .TMO_CYCLES(TMO)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wb           (wbBus),
        .key_o        (keyO),
        .ciphertext_o (ctO),
        .plaintext_i  (ptI),
        .kld_o        (kld),
        .ld_o         (ld),
        .dec_done_i   (decDone)
`ifdef AES_DEC_IRQ_EN
        ,
        .irq_o        (irq)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cycleNo = 0;
    int kldCount = 0;
    int ldCount = 0;
    int kldCycle = 0;
    int ldCycle = 0;
    int ackCycle = 0;

    logic         stubEnable = 1'b1;
    int           stubDelay = 3;
    int           stubWait = 0;
    logic         stubBusy = 1'b0;
    logic [127:0] coreKey = '0;
    logic [127:0] coreCt = '0;
    int           spurReqCnt = 0;
    int           spurAckCnt = 0;

    logic [31:0]  ctModel [4];
    logic [31:0]  keyModel [4];
    logic [127:0] ptModel = '0;
    logic         keyValidModel = 1'b0;

    // Behavioural core: FIPS-197 answer for the reference vector, reversible mix otherwise.
    function automatic logic [127:0] refDecrypt(input logic [127:0] k, input logic [127:0] c);
        if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
        return c ^ {k[63:0], k[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
    endfunction

    function automatic logic [127:0] packWords(input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w2, input logic [31:0] w3);
        return {w0, w1, w2, w3};
    endfunction

    // Cycle counter used to time pulses against bus acknowledges.
    always @(posedge clk) cycleNo++;

    // Pulse monitor plus core stub: latches core inputs on ld_o and answers after stubDelay cycles.
    always @(negedge clk) begin
        decDone = 1'b0;
        if (kld) begin kldCount++; kldCycle = cycleNo; end
        if (ld)  begin ldCount++;  ldCycle  = cycleNo; end
        if (stubBusy) begin
            if (stubWait == 0) begin
                decDone  = 1'b1;
                ptI      = refDecrypt(coreKey, coreCt);
                stubBusy = 1'b0;
            end else begin
                stubWait--;
            end
        end else if (spurReqCnt != spurAckCnt) begin
            decDone = 1'b1;
            ptI     = ~ptI;
            spurAckCnt++;
        end
        if (ld && stubEnable) begin
            coreKey  = keyO;
            coreCt   = ctO;
            stubWait = stubDelay;
            stubBusy = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [31:0] wdata,
                                 input logic [3:0] sel, output logic [31:0] rdata);
        int waitCnt;
        @(negedge clk);
        wbBus.wb_cyc_i = 1'b1;
        wbBus.wb_stb_i = 1'b1;
        wbBus.wb_we_i  = we;
        wbBus.wb_adr_i = adr;
        wbBus.wb_dat_i = wdata;
        wbBus.wb_sel_i = sel;
        waitCnt = 0;
        do begin
            @(posedge clk);
            #1;
            waitCnt++;
        end while (!wbBus.wb_ack_o && waitCnt < 8);
        checkOutput("bus_ack", 128'(wbBus.wb_ack_o), 128'd1);
        rdata    = wbBus.wb_dat_o;
        ackCycle = cycleNo;
        wbBus.wb_cyc_i = 1'b0;
        wbBus.wb_stb_i = 1'b0;
        wbBus.wb_we_i  = 1'b0;
    endtask

    task automatic wbWrite(input logic [7:0] adr, input logic [31:0] wdata, input logic [3:0] sel = 4'hF);
        logic [31:0] dummy;
        applyStimulus(1'b1, adr, wdata, sel, dummy);
    endtask

    task automatic wbRead(input logic [7:0] adr, output logic [31:0] rdata);
        applyStimulus(1'b0, adr, 32'h0, 4'hF, rdata);
    endtask

    task automatic writeKey(input logic [127:0] k);
        for (int i = 0; i < 4; i++) begin
            keyModel[i] = k[127-32*i -: 32];
            wbWrite(8'h10 + 8'(4*i), keyModel[i]);
        end
        keyValidModel = 1'b0;
    endtask

    task automatic writeCt(input logic [127:0] c);
        for (int i = 0; i < 4; i++) begin
            ctModel[i] = c[127-32*i -: 32];
            wbWrite(8'h00 + 8'(4*i), ctModel[i]);
        end
    endtask

    task automatic readPt(output logic [127:0] pt);
        logic [31:0] w [4];
        for (int i = 0; i < 4; i++) wbRead(8'h20 + 8'(4*i), w[i]);
        pt = packWords(w[0], w[1], w[2], w[3]);
    endtask

    task automatic waitIdle();
        logic [31:0] st;
        int polls;
        polls = 0;
        do begin
            wbRead(8'h34, st);
            polls++;
        end while (st[0] && polls < 80);
        checkOutput("wait_idle", 128'(st[0]), 128'd0);
    endtask

    task automatic waitUntil(input int target);
        while (cycleNo < target) @(negedge clk);
    endtask

    initial begin
        logic [31:0]  rd;
        logic [127:0] pt;
        logic [127:0] newKey;
        logic [127:0] newCt;
        int           kldBase;
        int           ldBase;
        int           startAck;
        int           mode;
        logic [31:0]  origCt0;

        wbBus.wb_cyc_i = 1'b0;
        wbBus.wb_stb_i = 1'b0;
        wbBus.wb_we_i  = 1'b0;
        wbBus.wb_adr_i = 8'h0;
        wbBus.wb_dat_i = 32'h0;
        wbBus.wb_sel_i = 4'h0;
        for (int i = 0; i < 4; i++) begin ctModel[i] = '0; keyModel[i] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_kld", 128'(kld), 128'd0);
        checkOutput("rst_ld", 128'(ld), 128'd0);
        checkOutput("rst_ack", 128'(wbBus.wb_ack_o), 128'd0);
        checkOutput("rst_dat", 128'(wbBus.wb_dat_o), 128'd0);
        rst = 1'b0;
        for (int r = 0; r < 14; r++) begin
            wbRead(8'(4*r), rd);
            checkOutput($sformatf("rst_reg_%0h", 4*r), 128'(rd), 128'd0);
        end

        // FIPS-197 vector with key expansion
        $display("[TB] FIPS-197 vector");
        writeKey(FIPS_KEY);
        writeCt(FIPS_CT);
        kldBase = kldCount;
        ldBase  = ldCount;
        wbWrite(8'h30, 32'h1);
        startAck = ackCycle;
        waitIdle();
        checkOutput("fips_kld_count", 128'(kldCount - kldBase), 128'd1);
        checkOutput("fips_ld_count", 128'(ldCount - ldBase), 128'd1);
        checkOutput("fips_kld_lat", 128'(kldCycle - startAck), 128'd1);
        checkOutput("fips_ld_after_kld", 128'(ldCycle - kldCycle), 128'(KEXP + 1));
        checkOutput("fips_ld_lat", 128'(ldCycle - startAck), 128'(KEXP + 2));
        readPt(pt);
        checkOutput("fips_pt", pt, FIPS_PT);
        ptModel = FIPS_PT;
        keyValidModel = 1'b1;
        wbRead(8'h34, rd);
        checkOutput("fips_status", 128'(rd), 128'h6);

        // Randomised reruns: key reuse, fresh key, KEY_NEW
        for (int it = 0; it < 6; it++) begin
            mode = (it < 3) ? it : int'($urandom_range(0, 2));
            stubDelay = int'($urandom_range(0, 20));
            if (mode == 1) begin
                newKey = {$urandom, $urandom, $urandom, $urandom};
                writeKey(newKey);
            end else if (mode == 2) begin
                wbWrite(8'h30, 32'h2);
                keyValidModel = 1'b0;
            end
            if (mode != 0) begin
                wbRead(8'h34, rd);
                checkOutput($sformatf("run%0d_status_pre", it), 128'(rd), 128'h2);
            end
            newCt = {$urandom, $urandom, $urandom, $urandom};
            writeCt(newCt);
            kldBase = kldCount;
            ldBase  = ldCount;
            wbWrite(8'h30, 32'h1);
            startAck = ackCycle;
            waitIdle();
            checkOutput($sformatf("run%0d_kld_count", it), 128'(kldCount - kldBase),
                        keyValidModel ? 128'd0 : 128'd1);
            checkOutput($sformatf("run%0d_ld_lat", it), 128'(ldCycle - startAck),
                        keyValidModel ? 128'd1 : 128'(KEXP + 2));
            checkOutput($sformatf("run%0d_ld_count", it), 128'(ldCount - ldBase), 128'd1);
            ptModel = refDecrypt(packWords(keyModel[0], keyModel[1], keyModel[2], keyModel[3]),
                                 packWords(ctModel[0], ctModel[1], ctModel[2], ctModel[3]));
            keyValidModel = 1'b1;
            readPt(pt);
            checkOutput($sformatf("run%0d_pt", it), pt, ptModel);
            wbRead(8'h34, rd);
            checkOutput($sformatf("run%0d_status", it), 128'(rd), 128'h6);
        end

        // Done strobe while idle is ignored
        spurReqCnt++;
        repeat (4) @(negedge clk);
        readPt(pt);
        checkOutput("spurious_pt", pt, ptModel);

        // CT/KEY writes and START while busy are discarded
        $display("[TB] busy writes");
        stubDelay = 30;
        newCt = {$urandom, $urandom, $urandom, $urandom};
        writeCt(newCt);
        origCt0 = ctModel[0];
        ldBase = ldCount;
        wbWrite(8'h30, 32'h1);
        wbWrite(8'h00, 32'hdeadbeef);
        wbWrite(8'h10, 32'h12345678);
        wbWrite(8'h30, 32'h1);
        wbRead(8'h00, rd);
        checkOutput("busy_ct0", 128'(rd), 128'(origCt0));
        wbRead(8'h10, rd);
        checkOutput("busy_key0", 128'(rd), 128'(keyModel[0]));
        waitIdle();
        checkOutput("busy_ld_count", 128'(ldCount - ldBase), 128'd1);
        ptModel = refDecrypt(packWords(keyModel[0], keyModel[1], keyModel[2], keyModel[3]),
                             packWords(ctModel[0], ctModel[1], ctModel[2], ctModel[3]));
        readPt(pt);
        checkOutput("busy_pt", pt, ptModel);
        wbRead(8'h34, rd);
        checkOutput("busy_status", 128'(rd), 128'h6);

        // Core never answers: timeout sets ERR, PT untouched, ERR is W1C
        $display("[TB] timeout");
        stubEnable = 1'b0;
        wbWrite(8'h30, 32'h1);
        startAck = ackCycle;
        waitUntil(startAck + 1 + 61);
        wbRead(8'h34, rd);
        checkOutput("tmo_still_busy", 128'(rd), 128'h5);
        waitUntil(startAck + 1 + 64);
        wbRead(8'h34, rd);
        checkOutput("tmo_status", 128'(rd), 128'hC);
        readPt(pt);
        checkOutput("tmo_pt", pt, ptModel);
        wbWrite(8'h34, 32'h8);
        wbRead(8'h34, rd);
        checkOutput("tmo_err_clear", 128'(rd), 128'h4);
        stubEnable = 1'b1;
        stubDelay = 2;

        // Byte-enabled writes and unmapped addresses
        wbWrite(8'h10, 32'h0000AB00, 4'b0010);
        keyModel[0][15:8] = 8'hAB;
        keyValidModel = 1'b0;
        wbRead(8'h10, rd);
        checkOutput("sel_key0", 128'(rd), 128'(keyModel[0]));
        wbRead(8'h34, rd);
        checkOutput("sel_status", 128'(rd), 128'h0);
        rd = $urandom;
        wbWrite(8'h04, rd, 4'b1001);
        ctModel[1][31:24] = rd[31:24];
        ctModel[1][7:0]   = rd[7:0];
        wbRead(8'h04, rd);
        checkOutput("sel_ct1", 128'(rd), 128'(ctModel[1]));
        wbWrite(8'h3C, 32'hFFFFFFFF);
        wbRead(8'h3C, rd);
        checkOutput("unmapped_3c", 128'(rd), 128'd0);

`ifdef AES_DEC_IRQ_EN
        // Interrupt follows DONE when enabled
        wbWrite(8'h30, 32'h4);
        wbRead(8'h30, rd);
        checkOutput("irq_en_rd", 128'(rd), 128'h4);
        wbWrite(8'h30, 32'h5);
        waitIdle();
        checkOutput("irq_high", 128'(irq), 128'd1);
        wbWrite(8'h34, 32'h2);
        repeat (2) @(negedge clk);
        checkOutput("irq_cleared", 128'(irq), 128'd0);
`else
        wbWrite(8'h30, 32'h4);
        wbRead(8'h30, rd);
        checkOutput("ctrl_rd_zero", 128'(rd), 128'h0);
`endif

        // Reset in the middle of key expansion
        $display("[TB] reset during KEXP");
        wbWrite(8'h30, 32'h2);
        wbWrite(8'h30, 32'h1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("kexp_kld_pulse", 128'(kld), 128'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_kld", 128'(kld), 128'd0);
        checkOutput("rst_mid_ld", 128'(ld), 128'd0);
        checkOutput("rst_mid_ack", 128'(wbBus.wb_ack_o), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ldBase = ldCount;
        for (int r = 0; r < 14; r++) begin
            wbRead(8'(4*r), rd);
            checkOutput($sformatf("post_rst_reg_%0h", 4*r), 128'(rd), 128'd0);
        end
        repeat (20) @(negedge clk);
        checkOutput("post_rst_no_ld", 128'(ldCount - ldBase), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
